coeff_seq_ctrl: RTL and testbench

COEFF_SEQ_CTRL -- requirements
Module: coeff_seq_ctrl

---
 rtl/coeff_seq_ctrl_pkg.sv | 15 +
 rtl/coeff_valid_dly.sv | 41 ++++
 rtl/coeff_seq_ctrl.sv | 106 ++++++++++
 tb/tb_coeff_seq_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_seq_ctrl_pkg.sv
// Shared FFT constants and sequencer state encoding.
// Defaults: N=128, 4-parallel datapath -> 32 twiddles/frame.
package coeff_seq_ctrl_pkg;

    localparam int FFT_N        = 128;
    localparam int FFT_PAR      = 4;
    localparam int COEFF_SIZE   = FFT_N / FFT_PAR;
    localparam int COEFF_ADDR_W = $clog2(COEFF_SIZE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/coeff_valid_dly.sv
// RD_LAT-stage shift line aligning valid/sync with ROM data.
// Ports: clk, rst_ni (async low), valid_i/sync_i in, valid_o/sync_o out.
module coeff_valid_dly #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic valid_i,
    input  logic sync_i,
    output logic valid_o,
    output logic sync_o
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [RD_LAT-1:0] sync_q, sync_d;

    always_comb begin
        valid_d    = valid_q;
        sync_d     = sync_q;
        valid_d[0] = valid_i;
        sync_d[0]  = sync_i;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            sync_d[i]  = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            sync_q  <= '0;
        end else begin
            valid_q <= valid_d;
            sync_q  <= sync_d;
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign sync_o  = sync_q[RD_LAT-1];

endmodule

// File: rtl/coeff_seq_ctrl.sv
// Twiddle-ROM address sequencer with back-to-back frame support.
// Ports: clk, rst (async low), start, in_valid in; coeff_addr,
// coeff_en, coeff_valid, frame_sync, frame_done, busy, overrun out.
module coeff_seq_ctrl
    import coeff_seq_ctrl_pkg::*;
#(
    parameter int SIZE   = COEFF_SIZE,
    parameter int ADDR_W = COEFF_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic              coeff_en,
    output logic              coeff_valid,
    output logic              frame_sync,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              pend_q, pend_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              run, last, sync_in;

    assign run  = (state_q == ST_RUN);
    assign last = run && in_valid && (count_q == LAST);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;
        coeff_en   = run && in_valid;
        coeff_addr = run ? count_q : '0;
        busy       = run;
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                pend_d  = 1'b0;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last) begin
                    count_d = '0;
                    pend_d  = 1'b0;
                    if (pend_q || start) begin
                        // queued frame follows with no bubble; a
                        // second request on this edge is lost
                        ovr_d = pend_q && start;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    if (in_valid) count_d = count_q + ADDR_W'(1);
                    if (start) begin
                        if (pend_q) ovr_d  = 1'b1;
                        else        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign frame_done = done_q;
    assign overrun    = ovr_q;
    assign sync_in    = coeff_en && (coeff_addr == '0);

    coeff_valid_dly #(
        .RD_LAT (RD_LAT)
    ) u_dly (
        .clk     (clk),
        .rst_ni  (rst),
        .valid_i (coeff_en),
        .sync_i  (sync_in),
        .valid_o (coeff_valid),
        .sync_o  (frame_sync)
    );

endmodule

// File: tb/tb_coeff_seq_ctrl.sv
// Bench for coeff_seq_ctrl: RD_LAT=1 and RD_LAT=3 instances on
// shared stimulus, compared each cycle with a frame-level model.
module tb_coeff_seq_ctrl;

    localparam int SIZE = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;

    logic [AW-1:0] addr1, addr3;
    logic en1, v1, s1, d1, b1, o1;
    logic en3, v3, s3, d3, b3, o3;

    always #5 clk = ~clk;

    coeff_seq_ctrl #(.SIZE(SIZE), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .coeff_addr(addr1), .coeff_en(en1), .coeff_valid(v1),
        .frame_sync(s1), .frame_done(d1), .busy(b1), .overrun(o1)
    );

    coeff_seq_ctrl #(.SIZE(SIZE), .ADDR_W(AW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .coeff_addr(addr3), .coeff_en(en3), .coeff_valid(v3),
        .frame_sync(s3), .frame_done(d3), .busy(b3), .overrun(o3)
    );

    // Frame-level reference: active frame, word position in it,
    // one queued request, and a history of issued words.
    typedef struct packed {
        logic       run;
        logic       pend;
        int         addr;
        logic       done;
        logic       ovr;
        logic [2:0] hv;
        logic [2:0] hs;
    } model_t;

    function automatic model_t model_next(model_t m, logic s, logic v);
        model_t n = m;
        logic fire = m.run && v;
        n.hv   = {m.hv[1:0], fire};
        n.hs   = {m.hs[1:0], fire && (m.addr == 0)};
        n.done = 1'b0;
        n.ovr  = 1'b0;
        if (!m.run) begin
            if (s) begin
                n.run  = 1'b1;
                n.addr = 0;
            end
        end else if (fire && m.addr == SIZE - 1) begin
            n.addr = 0;
            n.pend = 1'b0;
            if (m.pend || s) begin
                n.ovr = m.pend && s;
            end else begin
                n.run  = 1'b0;
                n.done = 1'b1;
            end
        end else begin
            n.addr = m.addr + (fire ? 1 : 0);
            if (s) begin
                if (m.pend) n.ovr  = 1'b1;
                else        n.pend = 1'b1;
            end
        end
        return n;
    endfunction

    model_t m;

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= model_next(m, start, in_valid);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int sb_checks = 0, sb_errors = 0;
    int n_sync = 0, n_done = 0, n_ovr = 0, n_busy = 0, n_en = 0;
    int n_v3 = 0, n_s3 = 0;
    int last_sync = 0, sync_gap = 0;
    int last_en = 0, last_v1 = 0, last_v3 = 0;

    always @(negedge clk) begin : mon
        automatic logic [AW-1:0] a_e;
        automatic logic          en_e;
        automatic logic [21:0]   act, exp_v;
        if (rst) begin
            en_e  = m.run && in_valid;
            a_e   = m.run ? m.addr[AW-1:0] : '0;
            act   = {addr1, en1, b1, v1, s1, d1, o1,
                     addr3, en3, b3, v3, s3, d3, o3};
            exp_v = {a_e, en_e, m.run, m.hv[0], m.hs[0], m.done, m.ovr,
                     a_e, en_e, m.run, m.hv[2], m.hs[2], m.done, m.ovr};
            sb_checks++;
            if (act !== exp_v) begin
                sb_errors++;
                $display("FAIL outputs cyc=%0d got=%b exp=%b",
                         cyc, act, exp_v);
            end
            if (s1) begin
                n_sync++;
                sync_gap  = cyc - last_sync;
                last_sync = cyc;
            end
            if (d1)  n_done++;
            if (o1)  n_ovr++;
            if (b1)  n_busy++;
            if (en1) begin n_en++; last_en = cyc; end
            if (v1)  last_v1 = cyc;
            if (v3)  begin n_v3++; last_v3 = cyc; end
            if (s3)  n_s3++;
        end
    end

    task automatic drive(input logic s, input logic v);
        @(posedge clk);
        #1;
        start    = s;
        in_valid = v;
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({addr1, en1, v1, s1, d1, b1, o1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 got=%b exp=0",
                     {addr1, en1, v1, s1, d1, b1, o1});
        end
        checks++;
        if ({addr3, en3, v3, s3, d3, b3, o3} !== '0) begin
            errors++;
            $display("FAIL reset_dut3 got=%b exp=0",
                     {addr3, en3, v3, s3, d3, b3, o3});
        end
        start    = 1'b0;
        in_valid = 1'b1;
        rst      = 1'b1;
        drive(0, 1);
        checks++;
        if ({b1, en1} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=00", {b1, en1});
        end
    endtask

    task automatic test_single_frame;
        int s0 = n_sync, d0 = n_done, b0 = n_busy, e0 = n_en;
        drive(1, 1);
        repeat (40) drive(0, 1);
        repeat (4) drive(0, 0);
        checks++;
        if (n_sync - s0 !== 1) begin
            errors++;
            $display("FAIL single_sync got=%0d exp=1", n_sync - s0);
        end
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL single_done got=%0d exp=1", n_done - d0);
        end
        checks++;
        if (n_busy - b0 !== SIZE) begin
            errors++;
            $display("FAIL single_busy got=%0d exp=%0d", n_busy - b0, SIZE);
        end
        checks++;
        if (n_en - e0 !== SIZE) begin
            errors++;
            $display("FAIL single_en got=%0d exp=%0d", n_en - e0, SIZE);
        end
        checks++;
        if (last_v1 - last_en !== 1) begin
            errors++;
            $display("FAIL single_lat got=%0d exp=1", last_v1 - last_en);
        end
    endtask

    task automatic test_gapped;
        int e0 = n_en, d0 = n_done, b0 = n_busy;
        drive(1, 0);
        for (int i = 0; i < 80; i++)
            drive(0, (i % 4 == 0) || (i % 4 == 3));
        repeat (3) drive(0, 0);
        checks++;
        if (n_en - e0 !== SIZE) begin
            errors++;
            $display("FAIL gapped_en got=%0d exp=%0d", n_en - e0, SIZE);
        end
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL gapped_done got=%0d exp=1", n_done - d0);
        end
        checks++;
        if (n_busy - b0 !== 64) begin
            errors++;
            $display("FAIL gapped_busy got=%0d exp=64", n_busy - b0);
        end
    endtask

    task automatic test_back_to_back;
        int s0 = n_sync, d0 = n_done, e0 = n_en, o0 = n_ovr;
        drive(1, 1);
        repeat (10) drive(0, 1);
        drive(1, 1);
        repeat (60) drive(0, 1);
        repeat (3) drive(0, 0);
        checks++;
        if (n_sync - s0 !== 2) begin
            errors++;
            $display("FAIL b2b_sync got=%0d exp=2", n_sync - s0);
        end
        checks++;
        if (sync_gap !== SIZE) begin
            errors++;
            $display("FAIL b2b_gap got=%0d exp=%0d", sync_gap, SIZE);
        end
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL b2b_done got=%0d exp=1", n_done - d0);
        end
        checks++;
        if (n_en - e0 !== 2 * SIZE || n_ovr - o0 !== 0) begin
            errors++;
            $display("FAIL b2b_en_ovr got=%0d/%0d exp=%0d/0",
                     n_en - e0, n_ovr - o0, 2 * SIZE);
        end
    endtask

    task automatic test_overrun;
        int o0 = n_ovr, e0 = n_en, d0 = n_done;
        drive(1, 1);
        repeat (5) drive(0, 1);
        drive(1, 1);
        drive(1, 1);
        drive(0, 1);
        checks++;
        if (o1 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_timing got=%b exp=1", o1);
        end
        repeat (80) drive(0, 1);
        repeat (3) drive(0, 0);
        checks++;
        if (n_ovr - o0 !== 1) begin
            errors++;
            $display("FAIL ovr_count got=%0d exp=1", n_ovr - o0);
        end
        checks++;
        if (n_en - e0 !== 2 * SIZE || n_done - d0 !== 1) begin
            errors++;
            $display("FAIL ovr_frames got=%0d/%0d exp=%0d/1",
                     n_en - e0, n_done - d0, 2 * SIZE);
        end
    endtask

    task automatic test_reset_mid;
        int d0 = n_done;
        drive(1, 1);
        repeat (18) drive(0, 1);
        checks++;
        if (addr1 !== AW'(17)) begin
            errors++;
            $display("FAIL mid_addr got=%0d exp=17", addr1);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({addr1, en1, v1, s1, d1, b1, o1,
             addr3, en3, v3, s3, d3, b3, o3} !== '0) begin
            errors++;
            $display("FAIL mid_async got=%b exp=0",
                     {addr1, en1, v1, s1, d1, b1, o1,
                      addr3, en3, v3, s3, d3, b3, o3});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) drive(0, 0);
        checks++;
        if (n_done - d0 !== 0) begin
            errors++;
            $display("FAIL mid_done got=%0d exp=0", n_done - d0);
        end
        drive(1, 1);
        drive(0, 1);
        checks++;
        if ({addr1, en1} !== {AW'(0), 1'b1}) begin
            errors++;
            $display("FAIL mid_restart got=%0d/%b exp=0/1", addr1, en1);
        end
        repeat (40) drive(0, 1);
        repeat (3) drive(0, 0);
    endtask

    task automatic test_lat3;
        int v0 = n_v3, s0 = n_s3;
        drive(1, 1);
        repeat (SIZE) drive(0, 1);
        repeat (6) drive(0, 0);
        checks++;
        if (last_v3 - last_en !== 3) begin
            errors++;
            $display("FAIL lat3_tail got=%0d exp=3", last_v3 - last_en);
        end
        checks++;
        if (n_v3 - v0 !== SIZE || n_s3 - s0 !== 1) begin
            errors++;
            $display("FAIL lat3_count got=%0d/%0d exp=%0d/1",
                     n_v3 - v0, n_s3 - s0, SIZE);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(15) == 0, $urandom_range(9) < 7);
            if ($urandom_range(399) == 0) begin
                #2 rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
            end
        end
        repeat (2 * SIZE + 4) drive(0, 1);
        checks++;
        if (b1 !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got=%b exp=0", b1);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_gapped;
        test_back_to_back;
        test_overrun;
        test_reset_mid;
        test_lat3;
        test_random;
        checks += sb_checks;
        errors += sb_errors;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
